// File: rtl/ntt_radix_ct_out_buf.sv
// Elastic output buffer behind the radix-R CT butterfly: avail-only input, valid/ready output,
// credit-style stall request. Optional sticky error port under NTT_RADIX_CT_OUT_BUF_ERR_EN.
module ntt_radix_ct_out_buf #(
   parameter int R        = 8,
   parameter int OP_W     = 32,
   parameter int SIDE_W   = 0,
   parameter int DEPTH    = 16,
   parameter int PIPE_LAT = 8,
   localparam int SW      = (SIDE_W > 0) ? SIDE_W : 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                a_rst,
   input  logic [R*OP_W-1:0]   in_x,
   input  logic [R-1:0]        in_avail,
   input  logic [SW-1:0]       in_side,
   output logic                in_stall_req,
   output logic [R*OP_W-1:0]   out_x,
   output logic [SW-1:0]       out_side,
   output logic                out_vld,
   input  logic                out_rdy,
   output logic [AW:0]         level
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
   ,
   output logic                error
`endif
);

   localparam int         ENT_W   = R*OP_W + SW;
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] PIPE_L  = (AW+1)'(PIPE_LAT);
   localparam logic [AW:0] ONE_L   = (AW+1)'(1);
   localparam logic [AW-1:0] PONE  = AW'(1);

   generate
      if (PIPE_LAT >= DEPTH) begin : g_bad_cfg
         $fatal(1, "ntt_radix_ct_out_buf: PIPE_LAT must be smaller than DEPTH");
      end
   endgenerate

   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next, wr_ptr_next;
   logic [AW:0]    level_reg, level_next;
   logic           full, fire, wr_en, overflow, lane_mismatch;
   logic [R-1:0]   lane_diff;
   logic [ENT_W-1:0] mem [DEPTH];
   logic [ENT_W-1:0] mem_rd_reg, byp_data_reg, head;
   logic           byp_reg;

   // Every lane's avail is compared against lane 0, which alone qualifies the write.
   genvar gi;
   generate
      for (gi = 0; gi < R; gi++) begin : g_lane_chk
         assign lane_diff[gi] = in_avail[gi] ^ in_avail[0];
      end
   endgenerate

   assign lane_mismatch = |lane_diff;
   assign out_vld       = (level_reg != '0);
   assign full          = (level_reg == DEPTH_L);
   assign fire          = out_vld & out_rdy;
   assign wr_en         = in_avail[0] & (~full | fire);
   assign overflow      = in_avail[0] & full & ~fire;

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (wr_en)
         wr_ptr_next = wr_ptr_reg + PONE;
      if (fire)
         rd_ptr_next = rd_ptr_reg + PONE;
      if (wr_en && !fire)
         level_next = level_reg + ONE_L;
      else if (fire && !wr_en)
         level_next = level_reg - ONE_L;
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
      end
   end

   // Head is prefetched with a registered read at the next read address; when that address is
   // the one being written this cycle the incoming beat is forwarded instead.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= {in_side, in_x};
      mem_rd_reg   <= mem[rd_ptr_next];
      byp_reg      <= wr_en && (wr_ptr_reg == rd_ptr_next);
      byp_data_reg <= {in_side, in_x};
   end

   assign head         = byp_reg ? byp_data_reg : mem_rd_reg;
   assign out_x        = out_vld ? head[R*OP_W-1:0] : '0;
   assign out_side     = out_vld ? head[R*OP_W +: SW] : '0;
   assign level        = level_reg;
   assign in_stall_req = ((DEPTH_L - level_reg) <= PIPE_L);

`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
   logic err_reg;
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst)
         err_reg <= 1'b0;
      else if (overflow || lane_mismatch)
         err_reg <= 1'b1;
   end
   assign error = err_reg;
`endif

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!a_rst) begin
         assert (!lane_mismatch)
            else $warning("ntt_radix_ct_out_buf: in_avail lanes disagree (%b)", in_avail);
         assert (!overflow)
            else $warning("ntt_radix_ct_out_buf: beat dropped while buffer full");
      end
   end
`endif

endmodule

// File: tb/tb_ntt_radix_ct_out_buf.sv
// Directed bench for ntt_radix_ct_out_buf: single beat, fill/stall, full read+write, overflow,
// stall-honouring wrap-around traffic and asynchronous mid-operation reset.
module tb_ntt_radix_ct_out_buf;
   localparam int R = 8, OP_W = 32, SIDE_W = 4, DEPTH = 16, PIPE_LAT = 8;
   localparam int W = R*OP_W;

   logic           clk = 1'b0;
   logic           a_rst;
   logic [W-1:0]   in_x;
   logic [R-1:0]   in_avail;
   logic [SIDE_W-1:0] in_side;
   logic           in_stall_req;
   logic [W-1:0]   out_x;
   logic [SIDE_W-1:0] out_side;
   logic           out_vld;
   logic           out_rdy;
   logic [4:0]     level;
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
   logic           error;
`endif

   int total_cnt = 0;
   int bad_cnt   = 0;

   ntt_radix_ct_out_buf #(
      .R(R), .OP_W(OP_W), .SIDE_W(SIDE_W), .DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)
   ) dut (
      .clk(clk), .a_rst(a_rst), .in_x(in_x), .in_avail(in_avail), .in_side(in_side),
      .in_stall_req(in_stall_req), .out_x(out_x), .out_side(out_side), .out_vld(out_vld),
      .out_rdy(out_rdy), .level(level)
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
      , .error(error)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] beat(input int v);
      logic [W-1:0] b;
      for (int i = 0; i < R; i++)
         b[i*OP_W +: OP_W] = 32'(v*256 + i);
      return b;
   endfunction

   task automatic drive(input int v);
      in_x     = beat(v);
      in_side  = 4'(v);
      in_avail = '1;
   endtask

   int q[$];
   int sent, rx, cyc, v0;
   logic [8:0] hist;
   logic [W-1:0] lanes1;

   initial begin
      a_rst = 1'b1; in_x = '0; in_avail = '0; in_side = '0; out_rdy = 1'b0;
      repeat (2) @(posedge clk);
      #3 a_rst = 1'b0;
      step();
      chk("rst_level", W'(level), 0);
      chk("rst_vld", W'(out_vld), 0);
      chk("rst_stall", W'(in_stall_req), 0);
      chk("rst_out_x", out_x, 0);
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
      chk("rst_error", W'(error), 0);
`endif

      // single beat, lane i = i+1, side 3
      for (int i = 0; i < R; i++) lanes1[i*OP_W +: OP_W] = 32'(i + 1);
      out_rdy = 1'b1; in_x = lanes1; in_side = 4'h3; in_avail = '1;
      step();
      in_avail = '0;
      chk("single_vld", W'(out_vld), 1);
      chk("single_x", out_x, lanes1);
      chk("single_side", W'(out_side), 3);
      chk("single_level1", W'(level), 1);
      step();
      chk("single_level0", W'(level), 0);
      chk("single_vld0", W'(out_vld), 0);
      chk("single_x0", out_x, 0);
      $display("txn single beat done");

      // fill 16 beats with out_rdy low
      out_rdy = 1'b0;
      for (int v = 0; v < DEPTH; v++) begin
         drive(v);
         step();
         q.push_back(v);
         chk($sformatf("fill_level%0d", v), W'(level), W'(v + 1));
         chk($sformatf("fill_stall%0d", v), W'(in_stall_req), W'(v + 1 >= 8));
      end

      // full with simultaneous read and write: level stays 16, order kept
      for (int k = 0; k < 5; k++) begin
         out_rdy = 1'b1;
         drive(16 + k);
         chk($sformatf("fullrw_head%0d", k), out_x, beat(q[0]));
         step();
         v0 = q.pop_front();
         q.push_back(16 + k);
         chk($sformatf("fullrw_level%0d", k), W'(level), 16);
      end
      in_avail = '0;
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
      chk("fullrw_error", W'(error), 0);
`endif

      // overflow: beat dropped while full and not read
      out_rdy = 1'b0;
      drive(99);
      step();
      in_avail = '0;
      chk("ovf_level", W'(level), 16);
      chk("ovf_head", out_x, beat(q[0]));
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
      chk("ovf_error", W'(error), 1);
`endif
      step();
      chk("hold_head", out_x, beat(q[0]));

      // drain: 5..20, beat 99 must not appear
      out_rdy = 1'b1;
      while (q.size() > 0) begin
         chk($sformatf("drain_x%0d", q[0]), out_x, beat(q[0]));
         chk($sformatf("drain_side%0d", q[0]), W'(out_side), W'(q[0] % 16));
         step();
         v0 = q.pop_front();
      end
      chk("drain_vld0", W'(out_vld), 0);
      chk("drain_level0", W'(level), 0);
      $display("txn fill/overflow/drain done");

      // wrap-around with random consumer and stall honoured after PIPE_LAT cycles
      a_rst = 1'b1; step(); a_rst = 1'b0; step();
`ifdef NTT_RADIX_CT_OUT_BUF_ERR_EN
      chk("wrap_error0", W'(error), 0);
`endif
      sent = 0; rx = 0; cyc = 0; hist = '0;
      while (rx < 40 && cyc < 3000) begin
         hist = {hist[7:0], in_stall_req};
         out_rdy = 1'($urandom_range(0, 1));
         if (out_vld && out_rdy) begin
            chk($sformatf("wrap_rx%0d", rx), out_x, beat(100 + rx));
            $display("txn wrap rx %0d", rx);
            rx++;
         end
         if (sent < 40 && !hist[8]) begin
            drive(100 + sent);
            sent++;
         end else begin
            in_avail = '0;
         end
         step();
         cyc++;
      end
      in_avail = '0; out_rdy = 1'b0;
      chk("wrap_count", W'(rx), 40);
      chk("wrap_level0", W'(level), 0);

      // mid-operation asynchronous reset
      for (int v = 0; v < 5; v++) begin
         drive(200 + v);
         step();
      end
      in_avail = '0;
      chk("mrst_level5", W'(level), 5);
      #3;
      a_rst = 1'b1;
      drive(55);
      #1;
      chk("mrst_vld", W'(out_vld), 0);
      chk("mrst_level", W'(level), 0);
      chk("mrst_stall", W'(in_stall_req), 0);
      chk("mrst_out_x", out_x, 0);
      step();
      in_avail = '0;
      a_rst = 1'b0;
      drive(77);
      step();
      in_avail = '0;
      chk("mrst_first_vld", W'(out_vld), 1);
      chk("mrst_first_x", out_x, beat(77));
      chk("mrst_first_level", W'(level), 1);
      out_rdy = 1'b1;
      step();
      chk("mrst_final_level", W'(level), 0);
      $display("txn mid-op reset done");

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
